// File: rtl/ddr3_cmd_responder.sv
// rtl/ddr3_cmd_responder.sv - DDR3 command responder model with per-bank state and 64x16 burst storage
// Decodes DDR3 command pins and plays back BL4 read/write bursts at CL/CWL latency.
module ddr3_cmd_responder #(
   parameter int CL  = 5,
   parameter int CWL = 5
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        CS,
   input  logic        RAS,
   input  logic        CAS,
   input  logic        WE,
   input  logic [14:0] Addr_in,
   input  logic [2:0]  BA_in,
   input  logic        LDM,
   input  logic        UDM,
   inout  wire  [15:0] DQ,
   inout  wire         LDQS,
   inout  wire         UDQS,
   output logic        busy,
   output logic        cmd_err
);

   typedef enum logic [2:0] {IDLE, WR_WAIT, WR_DATA, RD_WAIT, RD_DATA} state_t;

   localparam logic [3:0] WR_LAT = 4'(CWL - 1);
   localparam logic [3:0] RD_LAT = 4'(CL - 2);

   state_t            state_q, state_d;
   logic [3:0]        lat_q, lat_d;
   logic [1:0]        beat_q, beat_d;
   logic              busy_q, busy_d;
   logic              cmd_err_q, cmd_err_d;
   logic [7:0]        bank_open_q, bank_open_d;
   logic [7:0][14:0]  open_row_q, open_row_d;
   logic [2:0]        burst_ba_q, burst_ba_d;
   logic [2:0]        burst_col_q, burst_col_d;
   logic              burst_ap_q, burst_ap_d;
   logic              dq_oe_q, dq_oe_d;
   logic [15:0]       dq_out_q, dq_out_d;
   logic              dqs_q, dqs_d;

   logic [15:0]       mem_q [0:63];
   logic              mem_we;
   logic [5:0]        wr_addr;
   logic [15:0]       wr_old;
   logic [15:0]       wr_data;
   logic [1:0]        rd_beat;
   logic [15:0]       rd_data;
   logic              burst_done;

   logic [3:0] cmd;
   logic       is_act, is_rd, is_wr, is_pre;

   function automatic logic [5:0] mem_idx(input logic [2:0] ba, input logic [2:0] col,
                                          input logic [1:0] beat);
      logic [1:0] low;
      low = col[1:0] + beat;
      return {ba, col[2], low};
   endfunction

   assign cmd    = {CS, RAS, CAS, WE};
   assign is_act = (cmd == 4'b0011);
   assign is_rd  = (cmd == 4'b0101);
   assign is_wr  = (cmd == 4'b0100);
   assign is_pre = (cmd == 4'b0010);

   // Writes merge with the old word so masked bytes keep their contents.
   assign wr_addr = mem_idx(burst_ba_q, burst_col_q, beat_q);
   assign wr_old  = mem_q[wr_addr];
   assign wr_data = {UDM ? wr_old[15:8] : DQ[15:8], LDM ? wr_old[7:0] : DQ[7:0]};

   assign rd_beat = (state_q == RD_DATA) ? beat_q + 2'd1 : 2'd0;
   assign rd_data = mem_q[mem_idx(burst_ba_q, burst_col_q, rd_beat)];

   always_comb begin
      state_d     = state_q;
      lat_d       = lat_q;
      beat_d      = beat_q;
      cmd_err_d   = 1'b0;
      bank_open_d = bank_open_q;
      open_row_d  = open_row_q;
      burst_ba_d  = burst_ba_q;
      burst_col_d = burst_col_q;
      burst_ap_d  = burst_ap_q;
      dq_oe_d     = dq_oe_q;
      dq_out_d    = dq_out_q;
      dqs_d       = dqs_q;
      mem_we      = 1'b0;
      burst_done  = 1'b0;

      case (state_q)
         WR_WAIT: begin
            if (lat_q == 4'd1) begin
               state_d = WR_DATA;
               beat_d  = 2'd0;
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end
         WR_DATA: begin
            mem_we = 1'b1;
            if (beat_q == 2'd3) burst_done = 1'b1;
            else                beat_d     = beat_q + 2'd1;
         end
         RD_WAIT: begin
            if (lat_q == 4'd0) begin
               state_d  = RD_DATA;
               beat_d   = 2'd0;
               dq_oe_d  = 1'b1;
               dq_out_d = rd_data;
               dqs_d    = 1'b1;
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end
         RD_DATA: begin
            if (beat_q == 2'd3) begin
               burst_done = 1'b1;
               dq_oe_d    = 1'b0;
               dqs_d      = 1'b0;
            end else begin
               beat_d   = rd_beat;
               dq_out_d = rd_data;
               dqs_d    = ~rd_beat[0];
            end
         end
         default: ;
      endcase

      if (burst_done) begin
         state_d = IDLE;
         beat_d  = 2'd0;
         if (burst_ap_q) bank_open_d[burst_ba_q] = 1'b0;
      end

      // busy_q is the pre-edge value, so the completing edge still rejects new bursts.
      if (is_act) begin
         if (busy_q || bank_open_q[BA_in]) begin
            cmd_err_d = 1'b1;
         end else begin
            bank_open_d[BA_in] = 1'b1;
            open_row_d[BA_in]  = Addr_in;
         end
      end else if (is_rd || is_wr) begin
         if (busy_q || !bank_open_q[BA_in]) begin
            cmd_err_d = 1'b1;
         end else begin
            burst_ba_d  = BA_in;
            burst_col_d = Addr_in[2:0];
            burst_ap_d  = Addr_in[10];
            beat_d      = 2'd0;
            if (is_rd) begin
               state_d = RD_WAIT;
               lat_d   = RD_LAT;
            end else begin
               state_d = (CWL == 1) ? WR_DATA : WR_WAIT;
               lat_d   = WR_LAT;
            end
         end
      end else if (is_pre) begin
         if (busy_q && (Addr_in[10] || BA_in == burst_ba_q)) begin
            cmd_err_d = 1'b1;
         end else if (Addr_in[10]) begin
            bank_open_d = 8'h00;
         end else begin
            bank_open_d[BA_in] = 1'b0;
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q     <= IDLE;
         lat_q       <= 4'd0;
         beat_q      <= 2'd0;
         busy_q      <= 1'b0;
         cmd_err_q   <= 1'b0;
         bank_open_q <= 8'h00;
         open_row_q  <= '0;
         burst_ba_q  <= 3'd0;
         burst_col_q <= 3'd0;
         burst_ap_q  <= 1'b0;
         dq_oe_q     <= 1'b0;
         dq_out_q    <= 16'h0000;
         dqs_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         beat_q      <= beat_d;
         busy_q      <= busy_d;
         cmd_err_q   <= cmd_err_d;
         bank_open_q <= bank_open_d;
         open_row_q  <= open_row_d;
         burst_ba_q  <= burst_ba_d;
         burst_col_q <= burst_col_d;
         burst_ap_q  <= burst_ap_d;
         dq_oe_q     <= dq_oe_d;
         dq_out_q    <= dq_out_d;
         dqs_q       <= dqs_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET && mem_we) mem_q[wr_addr] <= wr_data;
   end

   assign DQ      = dq_oe_q ? dq_out_q : 16'hzzzz;
   assign LDQS    = dq_oe_q ? dqs_q : 1'bz;
   assign UDQS    = dq_oe_q ? dqs_q : 1'bz;
   assign busy    = busy_q;
   assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// tb/tb_ddr3_cmd_responder.sv - directed self-checking bench for ddr3_cmd_responder
// Undriven DQ reads as FFFF and undriven strobes as {LDQS,UDQS}=01 through net pulls.
module tb_ddr3_cmd_responder;

   localparam int CL  = 5;
   localparam int CWL = 5;

   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_DES = 4'b1111;

   localparam logic [15:0] VA = 16'hA00A;
   localparam logic [15:0] VB = 16'hB00B;
   localparam logic [15:0] VC = 16'hC00C;
   localparam logic [15:0] VD = 16'hD00D;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        CS = 1'b1, RAS = 1'b1, CAS = 1'b1, WE = 1'b1;
   logic [14:0] Addr_in = 15'd0;
   logic [2:0]  BA_in = 3'd0;
   logic        LDM = 1'b0, UDM = 1'b0;
   tri1  [15:0] DQ;
   tri0         LDQS;
   tri1         UDQS;
   logic        busy, cmd_err;

   logic [15:0] tb_dq = 16'h0000;
   logic        tb_dq_oe = 1'b0;
   assign DQ = tb_dq_oe ? tb_dq : 16'hzzzz;

   int n_chk = 0;
   int n_pass = 0;

   ddr3_cmd_responder #(.CL(CL), .CWL(CWL)) dut (
      .CLK(CLK), .RESET(RESET), .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE),
      .Addr_in(Addr_in), .BA_in(BA_in), .LDM(LDM), .UDM(UDM),
      .DQ(DQ), .LDQS(LDQS), .UDQS(UDQS), .busy(busy), .cmd_err(cmd_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic drive(input logic [3:0] c, input logic [2:0] ba, input logic [14:0] a);
      {CS, RAS, CAS, WE} = c;
      BA_in = ba;
      Addr_in = a;
      @(negedge CLK);
      {CS, RAS, CAS, WE} = C_DES;
   endtask

   task automatic chk_hiz(input string tag);
      chk({tag, "_dq"}, {16'h0, DQ}, 32'hFFFF);
      chk({tag, "_dqs"}, {30'h0, LDQS, UDQS}, 32'h1);
   endtask

   task automatic wr_burst(input logic [2:0] ba, input logic [2:0] col,
                           input logic [3:0][15:0] d, input logic [3:0][1:0] m);
      drive(C_WR, ba, {12'h000, col});
      chk("wr_acc_busy", {31'h0, busy}, 32'h1);
      chk("wr_acc_err", {31'h0, cmd_err}, 32'h0);
      repeat (CWL - 1) @(negedge CLK);
      for (int k = 0; k < 4; k++) begin
         tb_dq_oe = 1'b1;
         tb_dq = d[k];
         {UDM, LDM} = m[k];
         @(negedge CLK);
      end
      tb_dq_oe = 1'b0;
      {UDM, LDM} = 2'b00;
      chk("wr_done_busy", {31'h0, busy}, 32'h0);
   endtask

   task automatic rd_burst(input logic [2:0] ba, input logic [2:0] col, input logic ap,
                           input logic [3:0][15:0] e, input logic [3:0] inj_c,
                           input logic [2:0] inj_ba);
      drive(C_RD, ba, {4'h0, ap, 7'h00, col});
      chk("rd_acc_busy", {31'h0, busy}, 32'h1);
      chk("rd_acc_err", {31'h0, cmd_err}, 32'h0);
      if (inj_c != C_DES) begin
         drive(inj_c, inj_ba, 15'd0);
         chk("rd_inj_err", {31'h0, cmd_err}, 32'h1);
         repeat (CL - 2) @(negedge CLK);
      end else begin
         repeat (CL - 1) @(negedge CLK);
      end
      for (int k = 0; k < 4; k++) begin
         chk("rd_beat_dq", {16'h0, DQ}, {16'h0, e[k]});
         chk("rd_beat_dqs", {30'h0, LDQS, UDQS}, (k % 2 == 0) ? 32'h3 : 32'h0);
         chk("rd_beat_err", {31'h0, cmd_err}, 32'h0);
         @(negedge CLK);
      end
      chk_hiz("rd_after");
      chk("rd_after_busy", {31'h0, busy}, 32'h0);
   endtask

   initial begin
      repeat (3) @(negedge CLK);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_err", {31'h0, cmd_err}, 32'h0);
      chk_hiz("rst");
      RESET = 1'b1;

      // basic write then read back
      drive(C_ACT, 3'd5, 15'd1);
      chk("act5_err", {31'h0, cmd_err}, 32'h0);
      chk("act5_busy", {31'h0, busy}, 32'h0);
      wr_burst(3'd5, 3'd1, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, '0);
      rd_burst(3'd5, 3'd1, 1'b0, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, C_DES, 3'd0);

      // wrap within column group
      wr_burst(3'd5, 3'd3, {VD, VC, VB, VA}, '0);
      rd_burst(3'd5, 3'd0, 1'b0, {VA, VD, VC, VB}, C_DES, 3'd0);

      // byte masks
      drive(C_ACT, 3'd1, 15'd7);
      wr_burst(3'd1, 3'd0, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, '0);
      wr_burst(3'd1, 3'd0, {16'h0000, 16'h0000, 16'h1234, 16'h1234},
               {2'b11, 2'b11, 2'b01, 2'b10});
      rd_burst(3'd1, 3'd0, 1'b0, {16'hFFFF, 16'hFFFF, 16'h12FF, 16'hFF34}, C_DES, 3'd0);

      // read to closed bank
      drive(C_RD, 3'd2, 15'd0);
      chk("rd_closed_err", {31'h0, cmd_err}, 32'h1);
      chk("rd_closed_busy", {31'h0, busy}, 32'h0);
      @(negedge CLK);
      chk("rd_closed_err_pulse", {31'h0, cmd_err}, 32'h0);
      repeat (CL) @(negedge CLK);
      chk_hiz("rd_closed");

      // double ACT
      drive(C_ACT, 3'd0, 15'd3);
      chk("act0_first_err", {31'h0, cmd_err}, 32'h0);
      drive(C_ACT, 3'd0, 15'd4);
      chk("act0_second_err", {31'h0, cmd_err}, 32'h1);

      // commands rejected during a read burst
      rd_burst(3'd5, 3'd0, 1'b0, {VA, VD, VC, VB}, C_WR, 3'd5);
      rd_burst(3'd5, 3'd0, 1'b0, {VA, VD, VC, VB}, C_PRE, 3'd5);
      rd_burst(3'd5, 3'd0, 1'b0, {VA, VD, VC, VB}, C_ACT, 3'd3);

      // auto-precharge then PRE all
      rd_burst(3'd5, 3'd0, 1'b1, {VA, VD, VC, VB}, C_DES, 3'd0);
      drive(C_RD, 3'd5, 15'd0);
      chk("ap_closed_err", {31'h0, cmd_err}, 32'h1);
      chk("ap_closed_busy", {31'h0, busy}, 32'h0);
      drive(C_ACT, 3'd5, 15'd1);
      chk("reopen5_err", {31'h0, cmd_err}, 32'h0);
      drive(C_PRE, 3'd0, 15'h0400);
      chk("pre_all_err", {31'h0, cmd_err}, 32'h0);
      for (int b = 0; b < 8; b++) begin
         drive(C_ACT, 3'(b), 15'(b));
         chk("pre_all_act_err", {31'h0, cmd_err}, 32'h0);
      end
      drive(C_ACT, 3'd7, 15'd0);
      chk("act7_open_err", {31'h0, cmd_err}, 32'h1);

      // reset during beat 1 of a read
      drive(C_RD, 3'd5, 15'd1);
      repeat (CL - 1) @(negedge CLK);
      chk("rst_rd_beat0", {16'h0, DQ}, {16'h0, VC});
      @(negedge CLK);
      chk("rst_rd_beat1", {16'h0, DQ}, {16'h0, VD});
      RESET = 1'b0;
      @(negedge CLK);
      chk_hiz("rst_mid");
      chk("rst_mid_busy", {31'h0, busy}, 32'h0);
      chk("rst_mid_err", {31'h0, cmd_err}, 32'h0);
      drive(C_ACT, 3'd2, 15'd0);
      chk("rst_cmd_ignored_err", {31'h0, cmd_err}, 32'h0);
      RESET = 1'b1;
      for (int b = 0; b < 8; b++) begin
         drive(C_ACT, 3'(b), 15'd0);
         chk("rst_closed_act_err", {31'h0, cmd_err}, 32'h0);
      end
      rd_burst(3'd5, 3'd1, 1'b0, {VB, VA, VD, VC}, C_DES, 3'd0);
      rd_burst(3'd1, 3'd0, 1'b0, {16'hFFFF, 16'hFFFF, 16'h12FF, 16'hFF34}, C_DES, 3'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ddr3_cmd_responder.md
DDR3_CMD_RESPONDER -- requirements
Module: ddr3_cmd_responder

Interface
REQ-001 The block SHALL have parameter CL, default 5, read latency in CLK edges from command sample to first read beat (range 2..15).
REQ-002 The block SHALL have parameter CWL, default 5, write latency in CLK edges from command sample to first write beat (range 1..15).
REQ-003 The block SHALL have these ports: CLK in 1, sole clock, all logic on rising edge.
REQ-004 RESET  in  1  reset, synchronous and active-low.
REQ-005 CS, RAS, CAS, WE  in  1 each  active-low DDR3 command pins.
REQ-006 Addr_in  in  15  row address on ACT; column on READ/WRITE, A10 = auto-precharge; A10 on PRE = all banks.
REQ-007 BA_in  in  3  bank address.
REQ-008 LDM, UDM  in  1 each  write mask, 1 = byte not written (LDM DQ[7:0], UDM DQ[15:8]).
REQ-009 DQ  inout  16  data; driven only during read beats, else high-Z.
REQ-010 LDQS, UDQS  inout  1 each  strobes; driven only during read beats, else high-Z.
REQ-011 busy  out  1  high while a burst is pending or in progress.
REQ-012 cmd_err  out  1  one-cycle pulse on an illegal command.

Function
REQ-013 Decode {CS,RAS,CAS,WE} each edge: 1xxx DESEL, 0111 NOP, 0011 ACT, 0101 READ, 0100 WRITE, 0010 PRE, 0001 REF, 0000 MRS, 0110 ZQCL.
REQ-014 Per-bank state SHALL be bank_open[7:0] and open_row[7:0][14:0]; REF, MRS, ZQCL, DESEL, NOP SHALL have no effect on it.
REQ-015 ACT to a closed bank SHALL open it and store Addr_in as open_row; ACT to an open bank SHALL pulse cmd_err and change nothing.
REQ-016 PRE SHALL close BA_in's bank (A10=0) or all banks (A10=1); PRE to a closed bank is legal, no error.
REQ-017 Storage SHALL be 64 x 16 words indexed {BA_in, col[2], col[1:0]+beat mod 4}; contents not reset; row address is not part of the index.
REQ-018 Burst length fixed at 4 beats, one 16-bit beat per CLK, wrap within the 4-aligned column group.
REQ-019 FSM states IDLE, WR_WAIT, WR_DATA, RD_WAIT, RD_DATA; 4-bit latency counter, 2-bit beat counter.
REQ-020 IDLE + legal WRITE at edge T -> WR_WAIT; beats sampled at edges T+CWL..T+CWL+3 (WR_DATA), masked per LDM/UDM at same edge; then IDLE.
REQ-021 IDLE + legal READ at edge T -> RD_WAIT; DQ drives beat 0 in cycle after edge T+CL-1 so it is stable at edge T+CL; beats 1..3 at T+CL+1..T+CL+3; then IDLE.
REQ-022 During read beats LDQS = UDQS = ~beat[0] (1,0,1,0).
REQ-023 READ/WRITE to a closed bank SHALL pulse cmd_err and be ignored (state stays IDLE).
REQ-024 Any READ, WRITE or ACT sampled while busy=1 SHALL pulse cmd_err and be ignored; PRE to the burst bank while busy SHALL pulse cmd_err and be ignored; other PRE legal.
REQ-025 A10=1 on READ/WRITE SHALL close the bank on the edge after the last beat.
REQ-026 busy SHALL rise the edge after the accepted command and fall on the edge that completes beat 3; a new command is accepted on that same edge only if busy was 0 when sampled.
REQ-027 cmd_err SHALL assert in the cycle after the offending edge, for exactly one cycle.

Reset
REQ-028 RESET=0 at an edge SHALL force IDLE, all banks closed, counters 0, busy=0, cmd_err=0, DQ/LDQS/UDQS high-Z, any burst aborted mid-operation.
REQ-029 Commands sampled while RESET=0 SHALL be ignored; memory contents preserved.

Verification
REQ-030 ACT BA=5 row=1; WRITE BA=5 col=1 DQ beats 1111,2222,3333,4444 at CWL; READ BA=5 col=1 -> DQ 1111,2222,3333,4444 at CL, DQS 1,0,1,0, DQ high-Z after.
REQ-031 Wrap: WRITE col=3 beats A,B,C,D -> READ col=0 returns B,C,D,A.
REQ-032 Masks: existing 0xFFFF; WRITE beat 0x1234 with UDM=1 -> READ returns 0xFF34; LDM=1 -> 0x12FF.
REQ-033 Errors: READ to closed bank 2 -> cmd_err 1 cycle, DQ stays high-Z; ACT twice to bank 0 -> cmd_err; WRITE during read burst -> cmd_err, read data unaffected.
REQ-034 Auto-precharge: READ A10=1 bank 5 then READ bank 5 without ACT -> cmd_err; PRE A10=1 closes all eight banks.
REQ-035 RESET=0 during beat 1 of a read -> next cycle DQ/DQS high-Z, busy=0, all banks closed; prior written data readable after re-ACT.
